adpcm_encoder: RTL and testbench

ADPCM_ENCODER -- requirements
Module: adpcm_encoder

---
 rtl/adpcm_encoder.sv | 198 +++++++++++++++++++
 tb/tb_adpcm_encoder.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/adpcm_encoder.sv
`default_nettype none
// ============================================================================
// Module   : adpcm_encoder
// Purpose  : IMA ADPCM encoder that quantises one sample per pass through a
//            seven-state FSM. Optional macro ADPCM_ENC_STATE_LOAD_EN adds
//            init_valid/init_pred/init_index to preload predictor and index.
// Revision : 1.0 - initial release
// ============================================================================
module adpcm_encoder (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] sample_in,
  input  logic        sample_valid,
  output logic        sample_ready,
  output logic [3:0]  code,
  output logic        code_valid,
  input  logic        code_ready,
`ifdef ADPCM_ENC_STATE_LOAD_EN
  input  logic        init_valid,
  input  logic [15:0] init_pred,
  input  logic [6:0]  init_index,
`endif
  output logic [15:0] pred_out,
  output logic [6:0]  index_out
);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_DIFF = 3'd1;
  localparam logic [2:0] S_BIT2 = 3'd2;
  localparam logic [2:0] S_BIT1 = 3'd3;
  localparam logic [2:0] S_BIT0 = 3'd4;
  localparam logic [2:0] S_UPD  = 3'd5;
  localparam logic [2:0] S_OUT  = 3'd6;

  localparam logic [6:0] MAX_INDEX = 7'd88;

  localparam logic [14:0] STEP_TBL [0:88] = '{
    15'd7,     15'd8,     15'd9,     15'd10,    15'd11,    15'd12,    15'd13,    15'd14,
    15'd16,    15'd17,    15'd19,    15'd21,    15'd23,    15'd25,    15'd28,    15'd31,
    15'd34,    15'd37,    15'd41,    15'd45,    15'd50,    15'd55,    15'd60,    15'd66,
    15'd73,    15'd80,    15'd88,    15'd97,    15'd107,   15'd118,   15'd130,   15'd143,
    15'd157,   15'd173,   15'd190,   15'd209,   15'd230,   15'd253,   15'd279,   15'd307,
    15'd337,   15'd371,   15'd408,   15'd449,   15'd494,   15'd544,   15'd598,   15'd658,
    15'd724,   15'd796,   15'd876,   15'd963,   15'd1060,  15'd1166,  15'd1282,  15'd1411,
    15'd1552,  15'd1707,  15'd1878,  15'd2066,  15'd2272,  15'd2499,  15'd2749,  15'd3024,
    15'd3327,  15'd3660,  15'd4026,  15'd4428,  15'd4871,  15'd5358,  15'd5894,  15'd6484,
    15'd7132,  15'd7845,  15'd8630,  15'd9493,  15'd10442, 15'd11487, 15'd12635, 15'd13899,
    15'd15289, 15'd16818, 15'd18500, 15'd20350, 15'd22385, 15'd24623, 15'd27086, 15'd29794,
    15'd32767
  };

  logic [2:0]  state_q, state_d;
  logic        sample_ready_q, sample_ready_d;
  logic        code_valid_q, code_valid_d;
  logic [15:0] sample_q;
  logic [15:0] pred_q;
  logic [6:0]  index_q;
  logic [3:0]  code_q;
  logic [16:0] mag_q;
  logic [14:0] step_q;

  logic        w_accept;
  logic [16:0] w_diff;
  logic [16:0] w_mag;
  logic [14:0] w_trial;
  logic [3:0]  w_mask;
  logic        w_ge;
  logic [18:0] w_diffq;
  logic [19:0] w_pred_ext;
  logic [19:0] w_sum;
  logic [15:0] w_pred_sat;
  logic [7:0]  w_adj;
  logic [7:0]  w_idx_sum;
  logic [6:0]  w_idx_clamp;

`ifdef ADPCM_ENC_STATE_LOAD_EN
  // A load request wins over a sample offered in the same cycle.
  assign sample_ready = sample_ready_q && !init_valid;
`else
  assign sample_ready = sample_ready_q;
`endif
  assign w_accept   = sample_valid && sample_ready;
  assign code       = code_q;
  assign code_valid = code_valid_q;
  assign pred_out   = pred_q;
  assign index_out  = index_q;

  // FSM: state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= S_IDLE;
      sample_ready_q <= 1'b0;
      code_valid_q   <= 1'b0;
    end else begin
      state_q        <= state_d;
      sample_ready_q <= sample_ready_d;
      code_valid_q   <= code_valid_d;
    end
  end

  // FSM: next state
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (w_accept) state_d = S_DIFF;
      S_DIFF:  state_d = S_BIT2;
      S_BIT2:  state_d = S_BIT1;
      S_BIT1:  state_d = S_BIT0;
      S_BIT0:  state_d = S_UPD;
      S_UPD:   state_d = S_OUT;
      S_OUT:   if (code_ready) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // FSM: registered outputs follow the state being entered
  always_comb begin
    sample_ready_d = (state_d == S_IDLE);
    code_valid_d   = (state_d == S_OUT);
  end

  // Quantiser datapath
  always_comb begin
    w_diff  = {sample_q[15], sample_q} - {pred_q[15], pred_q};
    w_mag   = w_diff[16] ? (~w_diff + 17'd1) : w_diff;
    w_trial = step_q;
    w_mask  = 4'b0100;
    case (state_q)
      S_BIT1: begin w_trial = step_q >> 1; w_mask = 4'b0010; end
      S_BIT0: begin w_trial = step_q >> 2; w_mask = 4'b0001; end
      default: ;
    endcase
    w_ge = (mag_q >= {2'b00, w_trial});

    w_diffq = {4'b0000, step_q >> 3}
            + (code_q[2] ? {4'b0000, step_q}      : 19'd0)
            + (code_q[1] ? {4'b0000, step_q >> 1} : 19'd0)
            + (code_q[0] ? {4'b0000, step_q >> 2} : 19'd0);
    w_pred_ext = {{4{pred_q[15]}}, pred_q};
    w_sum      = code_q[3] ? (w_pred_ext - {1'b0, w_diffq})
                           : (w_pred_ext + {1'b0, w_diffq});
    // In range only when the top five bits are pure sign extension.
    if ((w_sum[19:15] == 5'b00000) || (w_sum[19:15] == 5'b11111))
      w_pred_sat = w_sum[15:0];
    else
      w_pred_sat = w_sum[19] ? 16'h8000 : 16'h7FFF;

    w_adj     = code_q[2] ? ({5'b00000, code_q[1:0], 1'b0} + 8'd2) : 8'hFF;
    w_idx_sum = {1'b0, index_q} + w_adj;
    if (w_idx_sum[7])
      w_idx_clamp = 7'd0;
    else if (w_idx_sum[6:0] > MAX_INDEX)
      w_idx_clamp = MAX_INDEX;
    else
      w_idx_clamp = w_idx_sum[6:0];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sample_q <= 16'd0;
      pred_q   <= 16'd0;
      index_q  <= 7'd0;
      code_q   <= 4'd0;
      mag_q    <= 17'd0;
      step_q   <= 15'd0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (w_accept) sample_q <= sample_in;
`ifdef ADPCM_ENC_STATE_LOAD_EN
          if (init_valid) begin
            pred_q  <= init_pred;
            index_q <= (init_index > MAX_INDEX) ? MAX_INDEX : init_index;
          end
`endif
        end
        S_DIFF: begin
          code_q <= {w_diff[16], 3'b000};
          mag_q  <= w_mag;
          step_q <= STEP_TBL[index_q];
        end
        S_BIT2, S_BIT1, S_BIT0: begin
          if (w_ge) begin
            code_q <= code_q | w_mask;
            mag_q  <= mag_q - {2'b00, w_trial};
          end
        end
        S_UPD: begin
          pred_q  <= w_pred_sat;
          index_q <= w_idx_clamp;
        end
        default: ;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_adpcm_encoder.sv
`default_nettype none
// ============================================================================
// Module   : tb_adpcm_encoder
// Purpose  : Directed and reference-model checks of adpcm_encoder.
// Revision : 1.0 - initial release
// ============================================================================
module tb_adpcm_encoder;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] sample_in = 16'd0;
  logic        sample_valid = 1'b0;
  logic        sample_ready;
  logic [3:0]  code;
  logic        code_valid;
  logic        code_ready = 1'b1;
  logic [15:0] pred_out;
  logic [6:0]  index_out;
`ifdef ADPCM_ENC_STATE_LOAD_EN
  logic        init_valid = 1'b0;
  logic [15:0] init_pred = 16'd0;
  logic [6:0]  init_index = 7'd0;
`endif

  int checks = 0;
  int errors = 0;
  int m_pred = 0;
  int m_idx  = 0;

  int tbl [89] = '{
    7, 8, 9, 10, 11, 12, 13, 14, 16, 17, 19, 21, 23, 25, 28, 31, 34, 37, 41, 45,
    50, 55, 60, 66, 73, 80, 88, 97, 107, 118, 130, 143, 157, 173, 190, 209, 230,
    253, 279, 307, 337, 371, 408, 449, 494, 544, 598, 658, 724, 796, 876, 963,
    1060, 1166, 1282, 1411, 1552, 1707, 1878, 2066, 2272, 2499, 2749, 3024, 3327,
    3660, 4026, 4428, 4871, 5358, 5894, 6484, 7132, 7845, 8630, 9493, 10442,
    11487, 12635, 13899, 15289, 16818, 18500, 20350, 22385, 24623, 27086, 29794,
    32767};

  adpcm_encoder dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .sample_in    (sample_in),
    .sample_valid (sample_valid),
    .sample_ready (sample_ready),
    .code         (code),
    .code_valid   (code_valid),
    .code_ready   (code_ready),
`ifdef ADPCM_ENC_STATE_LOAD_EN
    .init_valid   (init_valid),
    .init_pred    (init_pred),
    .init_index   (init_index),
`endif
    .pred_out     (pred_out),
    .index_out    (index_out)
  );

  always #5 clk = ~clk;

  initial begin
    #3000000;
    $display("FAIL watchdog: observed still running, required finished");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Classic IMA encoder decision, written independently from the RTL
  function automatic int ref_code(int s, int pred, int idx);
    int d, mag, st, c;
    st  = tbl[idx];
    d   = s - pred;
    c   = (d < 0) ? 8 : 0;
    mag = (d < 0) ? -d : d;
    if (mag >= st)     begin c += 4; mag -= st;     end
    if (mag >= st / 2) begin c += 2; mag -= st / 2; end
    if (mag >= st / 4) c += 1;
    return c;
  endfunction

  // Inverse quantizer
  task automatic dec_step(input int c, inout int pred, inout int idx);
    int st, dq;
    int adj [8] = '{-1, -1, -1, -1, 2, 4, 6, 8};
    st = tbl[idx];
    dq = st >> 3;
    if ((c & 4) != 0) dq += st;
    if ((c & 2) != 0) dq += st >> 1;
    if ((c & 1) != 0) dq += st >> 2;
    pred = ((c & 8) != 0) ? pred - dq : pred + dq;
    if (pred > 32767)  pred = 32767;
    if (pred < -32768) pred = -32768;
    idx += adj[c & 7];
    if (idx < 0)  idx = 0;
    if (idx > 88) idx = 88;
  endtask

  task automatic issue(input logic [15:0] s, input string tag);
    int n = 0;
    while (!sample_ready && n < 20) begin @(posedge clk); #1; n++; end
    sample_in    = s;
    sample_valid = 1'b1;
    @(posedge clk); #1;
    sample_valid = 1'b0;
    n = 0;
    while (!code_valid && n < 20) begin @(posedge clk); #1; n++; end
    // OUT is the sixth cycle counted from the accepting edge: five more edges.
    chk({tag, " latency"}, 32'(n), 32'd5);
  endtask

  task automatic enc_check(input logic [15:0] s, input logic [3:0] ec,
                           input logic [15:0] ep, input logic [6:0] ei, input string tag);
    issue(s, tag);
    chk({tag, " code"},  32'(code),      32'(ec));
    chk({tag, " pred"},  32'(pred_out),  32'(ep));
    chk({tag, " index"}, 32'(index_out), 32'(ei));
    @(posedge clk); #1;
    chk({tag, " code_valid after hs"},   32'(code_valid),   32'd0);
    chk({tag, " sample_ready after hs"}, 32'(sample_ready), 32'd1);
  endtask

  initial begin
    int s, c;
    logic [15:0] hold_code;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst sample_ready", 32'(sample_ready), 32'd0);
    chk("rst code_valid",   32'(code_valid),   32'd0);
    chk("rst pred",         32'(pred_out),     32'd0);
    chk("rst index",        32'(index_out),    32'd0);
    chk("rst code",         32'(code),         32'd0);
    rst_n = 1'b1;
    #1;
    chk("ready before first edge", 32'(sample_ready), 32'd0);
    @(posedge clk); #1;
    chk("ready after first edge", 32'(sample_ready), 32'd1);

    // Two-sample scenario
    enc_check(16'd100,   4'h7, 16'd11,   7'd8,  "s+100");
    enc_check(16'hFF9C,  4'hF, 16'hFFED, 7'd16, "s-100");

    // Asynchronous reset while in BIT1
    sample_in = 16'd500; sample_valid = 1'b1;
    @(posedge clk); #1;
    sample_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    chk("midrst code_valid",   32'(code_valid),   32'd0);
    chk("midrst pred",         32'(pred_out),     32'd0);
    chk("midrst index",        32'(index_out),    32'd0);
    chk("midrst sample_ready", 32'(sample_ready), 32'd0);
    repeat (3) @(posedge clk);
    #2;
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("midrst ready after release", 32'(sample_ready), 32'd1);
    repeat (8) begin
      @(posedge clk); #1;
      chk("midrst no code emitted", 32'(code_valid), 32'd0);
    end

    // Zero sample: lower index clamp
    enc_check(16'd0, 4'h0, 16'd0, 7'd0, "s0");

    // Backpressure
    code_ready = 1'b0;
    issue(16'd1000, "bp");
    chk("bp code",  32'(code),      32'h7);
    chk("bp pred",  32'(pred_out),  32'd11);
    chk("bp index", 32'(index_out), 32'd8);
    hold_code = 16'(code);
    repeat (5) begin
      @(posedge clk); #1;
      chk("bp code_valid held",   32'(code_valid),   32'd1);
      chk("bp code stable",       32'(code),         32'(hold_code[3:0]));
      chk("bp sample_ready low",  32'(sample_ready), 32'd0);
      chk("bp pred held",         32'(pred_out),     32'd11);
    end
    code_ready = 1'b1;
    @(posedge clk); #1;
    chk("bp released code_valid",   32'(code_valid),   32'd0);
    chk("bp released sample_ready", 32'(sample_ready), 32'd1);
    @(posedge clk); #1;
    chk("bp single handshake", 32'(code_valid), 32'd0);
    chk("bp pred after idle",  32'(pred_out),   32'd11);
    m_pred = 11;
    m_idx  = 8;

`ifdef ADPCM_ENC_STATE_LOAD_EN
    // Load beats a simultaneous sample; index clamps to 88
    init_valid = 1'b1; init_pred = 16'd32760; init_index = 7'd120;
    sample_valid = 1'b1; sample_in = 16'd1234;
    #1;
    chk("load sample_ready masked", 32'(sample_ready), 32'd0);
    @(posedge clk); #1;
    init_valid = 1'b0; sample_valid = 1'b0;
    chk("load pred",  32'(pred_out),  32'd32760);
    chk("load index", 32'(index_out), 32'd88);
    chk("load no accept", 32'(sample_ready), 32'd1);
    enc_check(16'd32767, 4'h0, 16'd32767, 7'd87, "sat");
    m_pred = 32767;
    m_idx  = 87;
`endif

    // Random stream against reference encoder and inverse quantizer
    for (int i = 0; i < 2000; i++) begin
      case ($urandom_range(0, 3))
        0: s = int'($signed(16'($urandom)));
        1: s = ($urandom_range(0, 1) == 1) ? 32767 : -32768;
        default: s = m_pred + int'($urandom_range(0, 4000)) - 2000;
      endcase
      if (s > 32767)  s = 32767;
      if (s < -32768) s = -32768;
      c = ref_code(s, m_pred, m_idx);
      dec_step(c, m_pred, m_idx);
      enc_check(16'(s), 4'(c), 16'(m_pred), 7'(m_idx), "rand");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
